cpu_sequencer: RTL

Multi-cycle control sequencer for the RISC-V core. Sits directly upstream of the byte-addressed instruction memory: it owns the program counter and the 3-bit phase code, and the instruction memory returns a word for that PC during the FETCH phase. The sequencer latches that word into the instruction register and steps each instruction through DECODE, EXECUTE, optional MEM, and optional WRITEBACK. It also handles branch/jump PC redirection, halt, and trap.

---
 rtl/cpu_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer: owns PC, IR, phase code and retire count.
// Retire is a decode of the registered phase qualified by this cycle's br_taken/mem_ready, so it lands in the final cycle.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [63:0] MEM_BYTES = 64'd64001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        mem_ready,
  output logic [2:0]  state_out,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_FENCE  = 7'b0001111;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  state_t      state;
  logic        redir;
  logic [31:0] redir_target;
  logic [6:0]  opcode;
  logic        opcode_legal;
  logic        fetch_ok;
  logic        br_misaligned;
  logic        is_mem;
  logic        is_short;
  logic        retire_now;
  logic        take_redir;
  logic [31:0] take_target;
  logic [31:0] next_pc;

  assign opcode    = ir_out[6:0];
  assign state_out = state;
  assign retire    = retire_now;

  // Widened compare so a PC near 2^32 cannot wrap past the memory limit.
  assign fetch_ok      = ({32'd0, pc_out} + 64'd3) < MEM_BYTES;
  assign br_misaligned = br_taken && (br_target[1:0] != 2'b00);
  assign is_mem        = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_short      = (opcode == OP_BRANCH) || (opcode == OP_FENCE);

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE: opcode_legal = 1'b1;
      default:                                    opcode_legal = 1'b0;
    endcase
  end

  assign retire_now = !rst && ((state == S_WB) ||
                               (state == S_EXEC && is_short && !br_misaligned) ||
                               (state == S_MEM && mem_ready && opcode == OP_STORE));

  // Branches retire in EXECUTE itself, before the redirect register has been written.
  always_comb begin
    take_redir  = redir;
    take_target = redir_target;
    if (state == S_EXEC) begin
      take_redir  = br_taken;
      take_target = br_target;
    end
  end

  assign next_pc = take_redir ? take_target : pc_out + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      pc_out       <= RESET_PC;
      ir_out       <= '0;
      instret      <= '0;
      halted       <= 1'b0;
      trap         <= 1'b0;
      redir        <= 1'b0;
      redir_target <= '0;
    end else begin
      instret <= instret + {31'd0, retire_now};
      if (retire_now) pc_out <= next_pc;
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (!fetch_ok) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else begin
            ir_out <= instr_in;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (ir_out == EBREAK) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!opcode_legal) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          redir        <= br_taken;
          redir_target <= br_target;
          if (br_misaligned) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else if (is_mem) begin
            state <= S_MEM;
          end else if (is_short) begin
            state <= S_FETCH;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) state <= (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        default: state <= state;
      endcase
    end
  end

endmodule
